// File: rtl/cond_flag_unit_pkg.sv
// Shared types for the condition/flag unit: ARM condition codes and the
// NZCV flag layout.
package cond_flag_unit_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

   localparam int unsigned N_IDX = 3;
   localparam int unsigned Z_IDX = 2;
   localparam int unsigned C_IDX = 1;
   localparam int unsigned V_IDX = 0;

   typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Execute-stage flag bus between the pipeline (master) and the
// condition/flag unit (slave).
interface cond_flag_unit_if
   import cond_flag_unit_pkg::*;
#(
   parameter int unsigned CNT_W = 8
);
   logic             valid_in;
   logic             stall;
   logic             flush;
   logic [3:0]       cond;
   logic [1:0]       flag_w;
   nzcv_t            alu_flags;
   logic             cnt_clr;
   logic             cond_ex;
   nzcv_t            flags_q;
   logic             valid_out;
   logic             pass_out;
   logic [CNT_W-1:0] ovf_count;

   modport master (
      output valid_in, stall, flush, cond, flag_w, alu_flags, cnt_clr,
      input  cond_ex, flags_q, valid_out, pass_out, ovf_count
   );

   modport slave (
      input  valid_in, stall, flush, cond, flag_w, alu_flags, cnt_clr,
      output cond_ex, flags_q, valid_out, pass_out, ovf_count
   );
endinterface

// File: rtl/cond_flag_unit_cond_check.sv
// Pure combinational evaluation of an ARM condition field against NZCV.
module cond_check
   import cond_flag_unit_pkg::*;
(
   input  cond_e cond,
   input  nzcv_t flags,
   output logic  pass
);

   logic n, z, c, v;

   always_comb begin
      n = flags[N_IDX];
      z = flags[Z_IDX];
      c = flags[C_IDX];
      v = flags[V_IDX];
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register with condition gating, commit pipeline
// register and saturating signed-overflow event counter.
module cond_flag_unit
   import cond_flag_unit_pkg::*;
#(
   parameter int unsigned CNT_W = 8
)
(
   input  logic           clk,
   input  logic           reset,
   cond_flag_unit_if.slave bus
);

   nzcv_t            flags_q, flags_d;
   logic             valid_q, valid_d;
   logic             pass_q,  pass_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             cond_pass;
   logic             live;
   logic             cond_ex;
   logic             commit;

   cond_check u_cond_check (
      .cond  (cond_e'(bus.cond)),
      .flags (flags_q),
      .pass  (cond_pass)
   );

   always_comb begin
      live    = bus.valid_in & ~bus.flush;
      // Gated by reset so nothing downstream sees a pass while registers clear.
      cond_ex = live & cond_pass & ~reset;
      commit  = cond_ex & ~bus.stall;

      flags_d = flags_q;
      if (commit && bus.flag_w[1]) begin
         flags_d[N_IDX] = bus.alu_flags[N_IDX];
         flags_d[Z_IDX] = bus.alu_flags[Z_IDX];
      end
      if (commit && bus.flag_w[0]) begin
         flags_d[C_IDX] = bus.alu_flags[C_IDX];
         flags_d[V_IDX] = bus.alu_flags[V_IDX];
      end

      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if (commit && bus.flag_w[0] && bus.alu_flags[V_IDX] && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      valid_d = live & ~bus.stall;
      pass_d  = commit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         flags_q <= flags_d;
         valid_q <= valid_d;
         pass_q  <= pass_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.cond_ex   = cond_ex;
   assign bus.flags_q   = flags_q;
   assign bus.valid_out = valid_q;
   assign bus.pass_out  = pass_q;
   assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: scoreboard of expected registered
// outputs fed by a reference model, plus direct checks of cond_ex.
module tb_cond_flag_unit;
   import cond_flag_unit_pkg::*;

   localparam int unsigned CW = 2;

   typedef struct packed {
      logic       v;
      logic       st;
      logic       fl;
      logic       clr;
      logic [3:0] cond;
      logic [1:0] fw;
      logic [3:0] alu;
   } stim_t;

   typedef struct packed {
      logic          valid;
      logic          pass;
      logic [3:0]    flags;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cond_flag_unit_if #(.CNT_W(CW)) bus ();

   cond_flag_unit #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   logic [3:0]    m_flags;
   logic [CW-1:0] m_cnt;
   logic          exp_cex;

   function automatic stim_t mk(input logic v, input logic st, input logic fl,
                                input logic clr, input logic [3:0] cond,
                                input logic [1:0] fw, input logic [3:0] alu);
      stim_t s;
      s = '{v: v, st: st, fl: fl, clr: clr, cond: cond, fw: fw, alu: alu};
      return s;
   endfunction

   // Reference: even/odd condition pairs, odd code inverts the even one.
   function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: return 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   task automatic apply(input stim_t s);
      logic live, commit;
      exp_t e;
      bus.valid_in  = s.v;
      bus.stall     = s.st;
      bus.flush     = s.fl;
      bus.cnt_clr   = s.clr;
      bus.cond      = s.cond;
      bus.flag_w    = s.fw;
      bus.alu_flags = s.alu;
      live    = s.v & ~s.fl;
      exp_cex = live & ref_pass(s.cond, m_flags);
      commit  = exp_cex & ~s.st;
      if (commit && s.fw[1]) m_flags[3:2] = s.alu[3:2];
      if (commit && s.fw[0]) m_flags[1:0] = s.alu[1:0];
      if (s.clr) m_cnt = '0;
      else if (commit && s.fw[0] && s.alu[0] && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
      e.valid = live & ~s.st;
      e.pass  = commit;
      e.flags = m_flags;
      e.cnt   = m_cnt;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_flags = '0;
      m_cnt   = '0;
      sb.delete();
   endtask

   task automatic test_reset();
      stim_t tbl[$];
      exp_t e;
      reset = 1'b1;
      bus.valid_in = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.cnt_clr = 1'b0;
      bus.cond = COND_AL; bus.flag_w = 2'b11; bus.alu_flags = 4'b1111;
      model_reset();
      #12;
      tests++;
      if (bus.cond_ex !== 1'b0) begin
         fails++; $display("FAIL reset_cond_ex: got %b want 0", bus.cond_ex);
      end
      tests++;
      if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== '0) begin
         fails++;
         $display("FAIL reset_state: got v=%b p=%b f=%b c=%0d want all 0",
                  bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count);
      end
      bus.valid_in = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      tbl = '{mk(1,0,0,0,COND_EQ,2'b00,4'h0), mk(1,0,0,0,COND_NE,2'b00,4'h0)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL reset_seq cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL reset_seq out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   task automatic test_cmp();
      stim_t tbl[$];
      exp_t e;
      tbl = '{mk(1,0,0,0,COND_AL,2'b11,4'b0100), mk(1,0,0,0,COND_EQ,2'b00,4'h0),
              mk(1,0,0,0,COND_GT,2'b00,4'h0)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL cmp cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL cmp out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   task automatic test_partial();
      stim_t tbl[$];
      exp_t e;
      tbl = '{mk(1,0,0,0,COND_AL,2'b11,4'b1111), mk(1,0,0,0,COND_AL,2'b10,4'b0000),
              mk(0,0,0,0,COND_AL,2'b11,4'b1010)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL partial cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL partial out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
      tests++;
      if (bus.flags_q !== 4'b0011) begin
         fails++; $display("FAIL partial_flags: got %b want 0011", bus.flags_q);
      end
   endtask

   task automatic test_gating();
      stim_t tbl[$];
      exp_t e;
      tbl = '{mk(1,0,0,0,COND_AL,2'b11,4'b0000), mk(1,0,0,0,COND_EQ,2'b11,4'b1001),
              mk(1,1,0,0,COND_AL,2'b11,4'b1001), mk(1,0,1,0,COND_AL,2'b11,4'b1001),
              mk(1,1,1,0,COND_AL,2'b11,4'b1001), mk(1,0,0,0,COND_NE,2'b00,4'h0)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL gating cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL gating out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   task automatic test_counter();
      stim_t tbl[$];
      exp_t e;
      logic [CW-1:0] want[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
      tbl = '{mk(0,0,0,1,COND_AL,2'b00,4'h0), mk(1,0,0,0,COND_AL,2'b01,4'b0001),
              mk(1,0,0,0,COND_AL,2'b01,4'b0001), mk(1,0,0,0,COND_AL,2'b01,4'b0001),
              mk(1,0,0,0,COND_AL,2'b01,4'b0001), mk(1,0,0,1,COND_AL,2'b01,4'b0001)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL counter cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e ||
             bus.ovf_count !== want[i]) begin
            fails++;
            $display("FAIL counter out[%0d]: got %b cnt=%0d want %b cnt=%0d", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count},
                     bus.ovf_count, e, want[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      stim_t tbl[$];
      exp_t e;
      apply(mk(1,0,0,0,COND_AL,2'b11,4'b1010));
      @(posedge clk); #1;
      e = sb.pop_front();
      bus.valid_in = 1'b0;
      #2;
      tests++;
      if (bus.flags_q !== 4'b1010) begin
         fails++; $display("FAIL async_pre flags: got %b want 1010", bus.flags_q);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== '0) begin
         fails++;
         $display("FAIL async_reset: got v=%b p=%b f=%b c=%0d want all 0",
                  bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count);
      end
      #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      tbl = '{mk(1,0,0,0,COND_EQ,2'b00,4'h0), mk(1,0,0,0,COND_NE,2'b00,4'h0)};
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL async_post cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL async_post out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   task automatic test_sweep();
      stim_t tbl[$];
      exp_t e;
      for (int f = 0; f < 16; f++) begin
         tbl.push_back(mk(1,0,0,0,COND_AL,2'b11,4'(f)));
         for (int c = 0; c < 16; c++) tbl.push_back(mk(1,0,0,0,4'(c),2'b00,4'h0));
      end
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++;
            $display("FAIL sweep cond_ex cond=%h flags=%b: got %b want %b",
                     tbl[i].cond, bus.flags_q, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL sweep out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t tbl[$];
      exp_t e;
      for (int k = 0; k < 300; k++) begin
         tbl.push_back(mk(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15))));
      end
      foreach (tbl[i]) begin
         apply(tbl[i]); #1;
         tests++;
         if (bus.cond_ex !== exp_cex) begin
            fails++; $display("FAIL b2b cond_ex[%0d]: got %b want %b", i, bus.cond_ex, exp_cex);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if ({bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count} !== e) begin
            fails++;
            $display("FAIL b2b out[%0d]: got %b want %b", i,
                     {bus.valid_out, bus.pass_out, bus.flags_q, bus.ovf_count}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cmp();
      test_partial();
      test_gating();
      test_counter();
      test_async_reset();
      test_sweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
